// File: rtl/pl_id_ex_reg.sv
// ID/EX pipeline register with bubble insertion and precise-exception capture.
//
// Ports
//   clk, rst            : clock, asynchronous active-high reset
//   stall, flush        : hold the stage / replace it with a bubble
//   *_id                : ID-stage instruction payload (valid, datapath, specifiers, control)
//   undefined_instr_ex  : ALU-control decode error for the instruction held in EX
//   exc_ack             : clears a captured exception
//   *_ex                : registered copies of the *_id payload
//   exc_pending, exc_pc : captured-exception flag and faulting PC
//   kill_ex             : combinational, valid_ex & undefined_instr_ex
module pl_id_ex_reg (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        valid_id,
    input  logic [31:0] pc_plus4_id,
    input  logic [31:0] rd1_id,
    input  logic [31:0] rd2_id,
    input  logic [31:0] sign_imm_id,
    input  logic [4:0]  rs_id,
    input  logic [4:0]  rt_id,
    input  logic [4:0]  rd_id,
    input  logic [5:0]  funct_id,
    input  logic [1:0]  alu_op_id,
    input  logic        reg_write_id,
    input  logic        mem_to_reg_id,
    input  logic        mem_read_id,
    input  logic        mem_write_id,
    input  logic        alu_src_id,
    input  logic        reg_dst_id,
    input  logic        branch_id,
    input  logic        undefined_instr_ex,
    input  logic        exc_ack,
    output logic        valid_ex,
    output logic [31:0] pc_plus4_ex,
    output logic [31:0] rd1_ex,
    output logic [31:0] rd2_ex,
    output logic [31:0] sign_imm_ex,
    output logic [4:0]  rs_ex,
    output logic [4:0]  rt_ex,
    output logic [4:0]  rd_ex,
    output logic [5:0]  funct_ex,
    output logic [1:0]  alu_op_ex,
    output logic        reg_write_ex,
    output logic        mem_to_reg_ex,
    output logic        mem_read_ex,
    output logic        mem_write_ex,
    output logic        alu_src_ex,
    output logic        reg_dst_ex,
    output logic        branch_ex,
    output logic        exc_pending,
    output logic [31:0] exc_pc,
    output logic        kill_ex
);

    localparam int unsigned XLEN    = 32;
    localparam int unsigned REG_W   = 5;
    localparam int unsigned FUNCT_W = 6;
    localparam int unsigned ALUOP_W = 2;

    typedef struct packed {
        logic               valid;
        logic [XLEN-1:0]    pc_plus4;
        logic [XLEN-1:0]    rd1;
        logic [XLEN-1:0]    rd2;
        logic [XLEN-1:0]    sign_imm;
        logic [REG_W-1:0]   rs;
        logic [REG_W-1:0]   rt;
        logic [REG_W-1:0]   rd;
        logic [FUNCT_W-1:0] funct;
        logic [ALUOP_W-1:0] alu_op;
        logic               reg_write;
        logic               mem_to_reg;
        logic               mem_read;
        logic               mem_write;
        logic               alu_src;
        logic               reg_dst;
        logic               branch;
    } stage_t;

    // A bubble is the all-zero payload.
    localparam stage_t BUBBLE = '0;

    typedef enum logic {
        EXC_IDLE    = 1'b0,
        EXC_PENDING = 1'b1
    } exc_state_t;

    stage_t     id_stage;
    stage_t     ex_stage;
    exc_state_t exc_state;

    assign id_stage = '{
        valid:      valid_id,
        pc_plus4:   pc_plus4_id,
        rd1:        rd1_id,
        rd2:        rd2_id,
        sign_imm:   sign_imm_id,
        rs:         rs_id,
        rt:         rt_id,
        rd:         rd_id,
        funct:      funct_id,
        alu_op:     alu_op_id,
        reg_write:  reg_write_id,
        mem_to_reg: mem_to_reg_id,
        mem_read:   mem_read_id,
        mem_write:  mem_write_id,
        alu_src:    alu_src_id,
        reg_dst:    reg_dst_id,
        branch:     branch_id
    };

    // Decode errors only matter for a real instruction.
    assign kill_ex = ex_stage.valid & undefined_instr_ex;

    // Stage register: kill/flush beat stall, stall beats load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_stage <= BUBBLE;
        end else if (kill_ex || flush) begin
            ex_stage <= BUBBLE;
        end else if (!stall) begin
            ex_stage <= id_stage;
        end
    end

    // Exception capture: first fault wins unless acknowledged on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exc_state   <= EXC_IDLE;
            exc_pending <= 1'b0;
            exc_pc      <= '0;
        end else begin
            case (exc_state)
                EXC_IDLE: begin
                    if (kill_ex) begin
                        exc_state   <= EXC_PENDING;
                        exc_pending <= 1'b1;
                        exc_pc      <= XLEN'(ex_stage.pc_plus4 - XLEN'(4));
                    end
                end
                EXC_PENDING: begin
                    if (exc_ack && kill_ex) begin
                        exc_pc <= XLEN'(ex_stage.pc_plus4 - XLEN'(4));
                    end else if (exc_ack) begin
                        exc_state   <= EXC_IDLE;
                        exc_pending <= 1'b0;
                        exc_pc      <= '0;
                    end
                end
                default: begin
                    exc_state   <= EXC_IDLE;
                    exc_pending <= 1'b0;
                    exc_pc      <= '0;
                end
            endcase
        end
    end

    assign valid_ex      = ex_stage.valid;
    assign pc_plus4_ex   = ex_stage.pc_plus4;
    assign rd1_ex        = ex_stage.rd1;
    assign rd2_ex        = ex_stage.rd2;
    assign sign_imm_ex   = ex_stage.sign_imm;
    assign rs_ex         = ex_stage.rs;
    assign rt_ex         = ex_stage.rt;
    assign rd_ex         = ex_stage.rd;
    assign funct_ex      = ex_stage.funct;
    assign alu_op_ex     = ex_stage.alu_op;
    assign reg_write_ex  = ex_stage.reg_write;
    assign mem_to_reg_ex = ex_stage.mem_to_reg;
    assign mem_read_ex   = ex_stage.mem_read;
    assign mem_write_ex  = ex_stage.mem_write;
    assign alu_src_ex    = ex_stage.alu_src;
    assign reg_dst_ex    = ex_stage.reg_dst;
    assign branch_ex     = ex_stage.branch;

endmodule

// File: tb/tb_pl_id_ex_reg.sv
// Scoreboard bench for pl_id_ex_reg: driver predicts each edge's outcome, monitor compares.
module tb_pl_id_ex_reg;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc4, rd1, rd2, imm;
        logic [4:0]  rs, rt, rd;
        logic [5:0]  funct;
        logic [1:0]  alu_op;
        logic        rw, mtr, mr, mw, as, rdst, br;
    } stage_s;

    typedef struct packed {
        stage_s      st;
        logic        pend;
        logic [31:0] epc;
    } exp_s;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic stall = 0, flush = 0, undefined_instr_ex = 0, exc_ack = 0;
    stage_s din = '0;

    logic        valid_ex, reg_write_ex, mem_to_reg_ex, mem_read_ex, mem_write_ex;
    logic        alu_src_ex, reg_dst_ex, branch_ex, exc_pending, kill_ex;
    logic [31:0] pc_plus4_ex, rd1_ex, rd2_ex, sign_imm_ex, exc_pc;
    logic [4:0]  rs_ex, rt_ex, rd_ex;
    logic [5:0]  funct_ex;
    logic [1:0]  alu_op_ex;

    int total = 0;
    int bad   = 0;
    exp_s sb[$];

    // Reference model state: contents of EX and the exception latch.
    stage_s      m_st  = '0;
    bit          m_pend = 0;
    logic [31:0] m_epc = '0;

    pl_id_ex_reg dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .valid_id(din.valid), .pc_plus4_id(din.pc4), .rd1_id(din.rd1), .rd2_id(din.rd2),
        .sign_imm_id(din.imm), .rs_id(din.rs), .rt_id(din.rt), .rd_id(din.rd),
        .funct_id(din.funct), .alu_op_id(din.alu_op),
        .reg_write_id(din.rw), .mem_to_reg_id(din.mtr), .mem_read_id(din.mr),
        .mem_write_id(din.mw), .alu_src_id(din.as), .reg_dst_id(din.rdst), .branch_id(din.br),
        .undefined_instr_ex(undefined_instr_ex), .exc_ack(exc_ack),
        .valid_ex(valid_ex), .pc_plus4_ex(pc_plus4_ex), .rd1_ex(rd1_ex), .rd2_ex(rd2_ex),
        .sign_imm_ex(sign_imm_ex), .rs_ex(rs_ex), .rt_ex(rt_ex), .rd_ex(rd_ex),
        .funct_ex(funct_ex), .alu_op_ex(alu_op_ex),
        .reg_write_ex(reg_write_ex), .mem_to_reg_ex(mem_to_reg_ex), .mem_read_ex(mem_read_ex),
        .mem_write_ex(mem_write_ex), .alu_src_ex(alu_src_ex), .reg_dst_ex(reg_dst_ex),
        .branch_ex(branch_ex), .exc_pending(exc_pending), .exc_pc(exc_pc), .kill_ex(kill_ex)
    );

    always #5 clk = ~clk;

    function automatic stage_s actual_stage();
        stage_s a;
        a = '{valid: valid_ex, pc4: pc_plus4_ex, rd1: rd1_ex, rd2: rd2_ex, imm: sign_imm_ex,
              rs: rs_ex, rt: rt_ex, rd: rd_ex, funct: funct_ex, alu_op: alu_op_ex,
              rw: reg_write_ex, mtr: mem_to_reg_ex, mr: mem_read_ex, mw: mem_write_ex,
              as: alu_src_ex, rdst: reg_dst_ex, br: branch_ex};
        return a;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every edge with an outstanding prediction is compared.
    always @(posedge clk) begin
        exp_s e, a;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            a = '{st: actual_stage(), pend: exc_pending, epc: exc_pc};
            total++;
            if (a !== e) begin
                bad++;
                $display("FAIL edge_state: got %h expected %h at %0t", a, e, $time);
            end
        end
    end

    function automatic stage_s rand_stage();
        stage_s s;
        s = '{valid: ($urandom_range(0, 3) != 0), pc4: $urandom, rd1: $urandom, rd2: $urandom,
              imm: $urandom, rs: 5'($urandom), rt: 5'($urandom), rd: 5'($urandom),
              funct: 6'($urandom), alu_op: 2'($urandom),
              rw: 1'($urandom), mtr: 1'($urandom), mr: 1'($urandom), mw: 1'($urandom),
              as: 1'($urandom), rdst: 1'($urandom), br: 1'($urandom)};
        return s;
    endfunction

    // One clock: drive inputs, check kill_ex, predict the edge, then let it happen.
    task automatic step(input stage_s in, input bit st, input bit fl, input bit ud, input bit ack);
        bit k;
        @(negedge clk);
        din = in; stall = st; flush = fl; undefined_instr_ex = ud; exc_ack = ack;
        #1;
        k = m_st.valid && ud;
        chk("kill_ex", 32'(kill_ex), 32'(k));
        if (k) begin
            if (!m_pend || ack) m_epc = m_st.pc4 - 32'd4;
            m_pend = 1;
        end else if (m_pend && ack) begin
            m_pend = 0;
            m_epc  = 0;
        end
        if (k || fl)      m_st = '0;
        else if (!st)     m_st = in;
        sb.push_back('{st: m_st, pend: m_pend, epc: m_epc});
        @(posedge clk);
        #2;
    endtask

    function automatic stage_s mk(input logic [31:0] pc4, input logic [31:0] rd1, input logic [31:0] rd2);
        stage_s s;
        s = '0;
        s.valid = 1; s.pc4 = pc4; s.rd1 = rd1; s.rd2 = rd2;
        s.rw = 1; s.mw = 1; s.alu_op = 2'b10; s.funct = 6'h20; s.rd = 5'd3;
        return s;
    endfunction

    // Reset between edges must clear everything without waiting for a clock.
    task automatic mid_reset();
        #1;
        rst = 1;
        #1;
        chk("rst_valid_ex", 32'(valid_ex), 0);
        chk("rst_pc4_ex", pc_plus4_ex, 0);
        chk("rst_rd1_ex", rd1_ex, 0);
        chk("rst_reg_write_ex", 32'(reg_write_ex), 0);
        chk("rst_exc_pending", 32'(exc_pending), 0);
        chk("rst_exc_pc", exc_pc, 0);
        @(posedge clk);
        @(negedge clk);
        rst = 0;
        m_st = '0; m_pend = 0; m_epc = 0;
    endtask

    initial begin
        stage_s s, held;
        #1;
        chk("init_valid_ex", 32'(valid_ex), 0);
        chk("init_exc_pending", 32'(exc_pending), 0);
        chk("init_exc_pc", exc_pc, 0);
        @(negedge clk);
        rst = 0;

        // Simple add loads with one-cycle latency.
        s = '0; s.valid = 1; s.alu_op = 2'b10; s.funct = 6'h20; s.rd1 = 5; s.rd2 = 7; s.pc4 = 32'h104;
        step(s, 0, 0, 0, 0);
        chk("add_valid_ex", 32'(valid_ex), 1);
        chk("add_rd1_ex", rd1_ex, 5);
        chk("add_rd2_ex", rd2_ex, 7);
        chk("add_pc4_ex", pc_plus4_ex, 32'h104);
        chk("add_funct_ex", 32'(funct_ex), 32'h20);
        chk("add_alu_op_ex", 32'(alu_op_ex), 2);

        // Stall holds EX while ID changes, then the current ID loads.
        for (int i = 0; i < 3; i++) begin
            step(rand_stage(), 1, 0, 0, 0);
            chk("stall_hold_rd1", rd1_ex, 5);
            chk("stall_hold_pc4", pc_plus4_ex, 32'h104);
        end
        s = mk(32'h180, 32'hAAAA_0001, 32'h5555_0002);
        step(s, 0, 0, 0, 0);
        chk("unstall_rd1", rd1_ex, 32'hAAAA_0001);

        // Flush wins over stall.
        step(mk(32'h1C0, 1, 2), 1, 1, 0, 0);
        chk("flush_valid_ex", 32'(valid_ex), 0);
        chk("flush_reg_write_ex", 32'(reg_write_ex), 0);
        chk("flush_mem_write_ex", 32'(mem_write_ex), 0);

        // Kill captures PC-4, second kill keeps the first, ack clears.
        step(mk(32'h208, 9, 9), 0, 0, 0, 0);
        step(mk(32'h300, 1, 1), 1, 0, 1, 0);
        chk("kill_valid_ex", 32'(valid_ex), 0);
        chk("kill_exc_pending", 32'(exc_pending), 1);
        chk("kill_exc_pc", exc_pc, 32'h204);
        step(mk(32'h308, 1, 1), 0, 0, 0, 0);
        step(mk(32'h400, 1, 1), 0, 0, 1, 0);
        chk("second_kill_exc_pc", exc_pc, 32'h204);
        step('0, 0, 0, 0, 1);
        chk("ack_exc_pending", 32'(exc_pending), 0);
        chk("ack_exc_pc", exc_pc, 0);

        // Ack ignored in idle, then wraparound at PC+4 = 0.
        step(mk(32'h0, 3, 3), 0, 0, 0, 1);
        chk("idle_ack_pending", 32'(exc_pending), 0);
        step('0, 0, 0, 1, 0);
        chk("wrap_exc_pc", exc_pc, 32'hFFFF_FFFC);

        // Simultaneous ack and kill in PENDING recaptures.
        step(mk(32'h500, 3, 3), 0, 0, 0, 0);
        step('0, 0, 0, 1, 1);
        chk("ack_kill_pending", 32'(exc_pending), 1);
        chk("ack_kill_exc_pc", exc_pc, 32'h4FC);

        // Reset mid-stall while loaded and pending.
        step(mk(32'h600, 4, 4), 0, 0, 0, 0);
        step(mk(32'h700, 4, 4), 1, 0, 0, 0);
        mid_reset();

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            step(rand_stage(), ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 5) == 0), ($urandom_range(0, 4) == 0));
        end
        held = m_st;
        mid_reset();
        step(rand_stage(), 0, 0, 0, 0);

        @(negedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
